// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared sizing helpers and defaults for the LED matrix scan driver
package matrix_pkg;

    localparam int DEFAULT_ROWS = 8;
    localparam int DEFAULT_COLS = 8;

    // Row index width; a single-row matrix still needs a 1-bit index.
    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Level driven on every unselected row line.
    function automatic logic row_off_level(input bit row_active_low);
        return row_active_low;
    endfunction

endpackage

// File: rtl/matrix_frame_bank.sv
// rtl/matrix_frame_bank.sv - ROWS x COLS frame register file, one sync write port, one async read port
module matrix_frame_bank
    import matrix_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS,
    parameter int RW   = row_width(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [COLS-1:0] wdata,
    input  logic [RW-1:0]   raddr,
    output logic [COLS-1:0] rdata
);

    localparam logic [RW:0] ROWS_EXT = (RW + 1)'(ROWS);

    logic [COLS-1:0] mem [ROWS];
    logic            addr_ok;

    // Addresses past the last row exist only for non-power-of-2 ROWS; drop them.
    assign addr_ok = ({1'b0, waddr} < ROWS_EXT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && addr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - double-buffered ROWS x COLS LED matrix scan driver with tear-free commit
// Optional: MATRIX_GHOST_BLANK_EN blanks the first cycle of every row dwell.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int ROWS           = DEFAULT_ROWS,
    parameter int COLS           = DEFAULT_COLS,
    parameter int SCAN_DIV       = 1,
    parameter int ROW_ACTIVE_LOW = 1,
    localparam int RW            = row_width(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            commit,
    output logic            commit_pending,
    output logic            frame_start,
    output logic [ROWS-1:0] dot_row,
    output logic [COLS-1:0] dot_col
);

    localparam int            DW           = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST     = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(ROWS - 1);
    localparam logic [ROWS-1:0] ROW_INACTIVE = {ROWS{row_off_level(ROW_ACTIVE_LOW != 0)}};

    logic [DW-1:0]   div_cnt;
    logic [RW-1:0]   row_cnt;
    logic            bank_sel;
    logic            div_wrap;
    logic            boundary;
    logic            accept;
    logic [COLS-1:0] rdata0;
    logic [COLS-1:0] rdata1;
    logic [COLS-1:0] front_row;
    logic [ROWS-1:0] row_onehot;
    logic [ROWS-1:0] next_row;
    logic [COLS-1:0] next_col;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign boundary = div_wrap && (row_cnt == ROW_LAST);
    assign wr_ready = !commit_pending;
    assign accept   = wr_valid && wr_ready;

    // bank_sel names the front bank; writes always go to the other one.
    matrix_frame_bank #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (accept && bank_sel),
        .waddr (wr_row),
        .wdata (wr_data),
        .raddr (row_cnt),
        .rdata (rdata0)
    );

    matrix_frame_bank #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (accept && !bank_sel),
        .waddr (wr_row),
        .wdata (wr_data),
        .raddr (row_cnt),
        .rdata (rdata1)
    );

    assign front_row = bank_sel ? rdata1 : rdata0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt        <= '0;
            row_cnt        <= '0;
            bank_sel       <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // Swap only on the last dwell cycle of the last row so no frame is ever mixed.
            if (boundary && (commit_pending || commit)) begin
                bank_sel       <= ~bank_sel;
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        row_onehot = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_cnt == RW'(i)) begin
                row_onehot[ROWS-1-i] = 1'b1;
            end
        end
        next_row = (ROW_ACTIVE_LOW != 0) ? ~row_onehot : row_onehot;
        next_col = front_row;
`ifdef MATRIX_GHOST_BLANK_EN
        if ((SCAN_DIV > 1) && (div_cnt == '0)) begin
            next_row = ROW_INACTIVE;
            next_col = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dot_row     <= ROW_INACTIVE;
            dot_col     <= '0;
            frame_start <= 1'b0;
        end else begin
            dot_row     <= next_row;
            dot_col     <= next_col;
            frame_start <= (row_cnt == '0) && (div_cnt == '0);
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - self-checking bench: three parameter sets against a frame-level reference model
module tb_matrix_scan_driver;

`ifdef MATRIX_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    localparam int P_ROWS [3] = '{8, 8, 5};
    localparam int P_DIV  [3] = '{1, 3, 1};
    localparam int P_AL   [3] = '{1, 1, 0};

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       commit;

    logic       ready_a, pend_a, fs_a;
    logic [7:0] row_a, col_a;
    logic       ready_b, pend_b, fs_b;
    logic [7:0] row_b, col_b;
    logic       ready_c, pend_c, fs_c;
    logic [4:0] row_c;
    logic [7:0] col_c;

    matrix_scan_driver #(.ROWS(8), .COLS(8), .SCAN_DIV(1), .ROW_ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready_a), .wr_row(wr_row),
        .wr_data(wr_data), .commit(commit), .commit_pending(pend_a), .frame_start(fs_a),
        .dot_row(row_a), .dot_col(col_a));

    matrix_scan_driver #(.ROWS(8), .COLS(8), .SCAN_DIV(3), .ROW_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready_b), .wr_row(wr_row),
        .wr_data(wr_data), .commit(commit), .commit_pending(pend_b), .frame_start(fs_b),
        .dot_row(row_b), .dot_col(col_b));

    matrix_scan_driver #(.ROWS(5), .COLS(8), .SCAN_DIV(1), .ROW_ACTIVE_LOW(0)) dut_c (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready_c), .wr_row(wr_row),
        .wr_data(wr_data), .commit(commit), .commit_pending(pend_c), .frame_start(fs_c),
        .dot_row(row_c), .dot_col(col_c));

    logic [7:0] a_row [3];
    logic [7:0] a_col [3];
    logic       a_fs [3];
    logic       a_pend [3];
    logic       a_ready [3];

    always_comb begin
        a_row[0] = row_a;  a_row[1] = row_b;  a_row[2] = {3'b000, row_c};
        a_col[0] = col_a;  a_col[1] = col_b;  a_col[2] = col_c;
        a_fs[0] = fs_a;    a_fs[1] = fs_b;    a_fs[2] = fs_c;
        a_pend[0] = pend_a; a_pend[1] = pend_b; a_pend[2] = pend_c;
        a_ready[0] = ready_a; a_ready[1] = ready_b; a_ready[2] = ready_c;
    end

    // Reference model: two frames per instance, a pending flag and a cycle count since reset.
    logic [7:0] m_front [3][8];
    logic [7:0] m_back  [3][8];
    bit         m_pend  [3];
    int         m_cyc   [3];
    logic [7:0] e_row [3];
    logic [7:0] e_col [3];
    bit         e_fs  [3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       v;
        logic [2:0] r;
        logic [7:0] d;
        logic       c;
        logic [7:0] e_row;
        logic [7:0] e_col;
        logic       e_fs;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] pat [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected one");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 8; r++) begin
                m_front[i][r] = 8'h00;
                m_back[i][r]  = 8'h00;
            end
            m_pend[i] = 1'b0;
            m_cyc[i]  = 0;
        end
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        commit   = 1'b0;
        rst      = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] mask;
            mask = 8'((1 << P_ROWS[i]) - 1);
            check($sformatf("rst_row%0d", i), a_row[i], (P_AL[i] != 0) ? mask : 8'h00);
            check($sformatf("rst_col%0d", i), a_col[i], 8'h00);
            check($sformatf("rst_fs%0d", i), a_fs[i], 1'b0);
            check($sformatf("rst_pend%0d", i), a_pend[i], 1'b0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic model_step(input logic v, input logic [2:0] r, input logic [7:0] d, input logic c);
        for (int i = 0; i < 3; i++) begin
            int rows;
            int dv;
            int row;
            int ph;
            logic [7:0] mask;
            logic [7:0] oh;
            logic [7:0] tmp;
            rows = P_ROWS[i];
            dv   = P_DIV[i];
            row  = (m_cyc[i] / dv) % rows;
            ph   = m_cyc[i] % dv;
            mask = 8'((1 << rows) - 1);
            oh   = 8'(1 << (rows - 1 - row));
            e_row[i] = (P_AL[i] != 0) ? (~oh & mask) : oh;
            e_col[i] = m_front[i][row];
            e_fs[i]  = (row == 0) && (ph == 0);
            if (GHOST && dv > 1 && ph == 0) begin
                e_row[i] = (P_AL[i] != 0) ? mask : 8'h00;
                e_col[i] = 8'h00;
            end
            if (v && !m_pend[i] && int'(r) < rows) m_back[i][r] = d;
            if (row == rows - 1 && ph == dv - 1 && (m_pend[i] || c)) begin
                for (int k = 0; k < 8; k++) begin
                    tmp           = m_front[i][k];
                    m_front[i][k] = m_back[i][k];
                    m_back[i][k]  = tmp;
                end
                m_pend[i] = 1'b0;
            end else if (c) begin
                m_pend[i] = 1'b1;
            end
            m_cyc[i]++;
        end
    endtask

    task automatic tick(input logic v, input logic [2:0] r, input logic [7:0] d, input logic c);
        wr_valid = v;
        wr_row   = r;
        wr_data  = d;
        commit   = c;
        model_step(v, r, d, c);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("row%0d", i), a_row[i], e_row[i]);
            check($sformatf("col%0d", i), a_col[i], e_col[i]);
            check($sformatf("fs%0d", i), a_fs[i], e_fs[i]);
            check($sformatf("pend%0d", i), a_pend[i], m_pend[i]);
            check($sformatf("ready%0d", i), a_ready[i], !m_pend[i]);
        end
    endtask

    task automatic idle_until_a_phase(input int phase);
        int guard;
        guard = 0;
        while (((m_cyc[0] % 8) != phase || m_pend[0]) && guard < 64) begin
            tick(1'b0, 3'd0, 8'h00, 1'b0);
            guard++;
        end
        check("phase_wait_a", guard < 64, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_row   = 3'd0;
        wr_data  = 8'h00;
        commit   = 1'b0;

        tbl[0] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'h7F, 8'h00, 1'b1};
        tbl[1] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hBF, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 3'd0, 8'h55, 1'b0, 8'hDF, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hEF, 8'h00, 1'b0};
        tbl[4] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hF7, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hFB, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hFD, 8'h00, 1'b0};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hFE, 8'h00, 1'b0};
        tbl[8] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'h7F, 8'h00, 1'b1};
        pat = '{8'h10, 8'h00, 8'h18, 8'h24, 8'h3C, 8'h42, 8'h81, 8'hE7};

        #1;
        do_reset();

        for (int k = 0; k < 9; k++) begin
            tick(tbl[k].v, tbl[k].r, tbl[k].d, tbl[k].c);
            check($sformatf("tbl_row[%0d]", k), row_a, tbl[k].e_row);
            check($sformatf("tbl_col[%0d]", k), col_a, tbl[k].e_col);
            check($sformatf("tbl_fs[%0d]", k), fs_a, tbl[k].e_fs);
        end

        // Fill the back frame, commit mid-frame, expect the whole next frame to be new data.
        for (int k = 0; k < 8; k++) tick(1'b1, 3'(k), pat[k], 1'b0);
        idle_until_a_phase(3);
        tick(1'b0, 3'd0, 8'h00, 1'b1);
        check("commit_pend_a", pend_a, 1'b1);
        check("commit_ready_a", ready_a, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 3'd0, 8'h00, 1'b0);
        check("swap_done_a", pend_a, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 3'd0, 8'h00, 1'b0);
            check($sformatf("newframe_col[%0d]", k), col_a, pat[k]);
        end

        // Commit and write together on the boundary cycle: the write rides along with the swap.
        idle_until_a_phase(7);
        tick(1'b1, 3'd7, 8'hFF, 1'b1);
        check("bnd_nopend_a", pend_a, 1'b0);
        for (int k = 0; k < 8; k++) tick(1'b0, 3'd0, 8'h00, 1'b0);
        check("bnd_row7_col_a", col_a, 8'hFF);
        check("bnd_row7_sel_a", row_a, 8'hFE);

        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                 ($urandom_range(0, 9) == 0));
        end

        // Reset while a commit is pending: the swap must be forgotten and the banks cleared.
        idle_until_a_phase(2);
        tick(1'b0, 3'd0, 8'h00, 1'b1);
        check("midcommit_pend_a", pend_a, 1'b1);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 3'd0, 8'h00, 1'b0);
            check($sformatf("postrst_col[%0d]", k), col_a, 8'h00);
        end
        tick(1'b0, 3'd0, 8'h00, 1'b1);
        for (int k = 0; k < 24; k++) tick(1'b0, 3'd0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_scan_driver.md
Name: matrix_scan_driver

Overview:
Parametrised successor to the fixed-pattern 8x8 dot-matrix driver. Time-multiplexes a ROWS x COLS LED matrix from a double-buffered frame store instead of a hard-coded pattern table. The board logic, for example the Game-of-Life engine, writes the next frame row by row into the back bank. It then commits the frame, and the swap is tear-free at a frame boundary. The block sits between the simulation core and the matrix pins.

Parameters:
ROWS, 8, number of matrix rows scanned (>=2)
COLS, 8, number of column bits per row (>=1)
SCAN_DIV, 1, clk cycles each row stays lit (>=1)
ROW_ACTIVE_LOW, 1, 1: selected row driven 0, others 1; 0: one-hot high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
wr_valid  in  1  row write request
wr_ready  out  1  write accepted when wr_valid&&wr_ready
wr_row  in  RW=$clog2(ROWS)  target row of back bank
wr_data  in  COLS  column bits; bit COLS-1 is leftmost
commit  in  1  request back/front swap at next frame boundary
commit_pending  out  1  swap requested, not yet done
frame_start  out  1  one-cycle pulse, row 0 of a frame on outputs
dot_row  out  ROWS  row select; bit ROWS-1 is row 0
dot_col  out  COLS  column data for the selected row

Behaviour:
- Reset (rst=0, async): div_cnt=0, row_cnt=0, bank_sel=0, commit_pending=0, frame_start=0, both banks all-zero, dot_col=0, dot_row=all inactive (all 1s if ROW_ACTIVE_LOW, else 0).
- Scan: div_cnt counts 0..SCAN_DIV-1. On div_cnt wrap, row_cnt increments, wrapping ROWS-1 -> 0.
- Boundary cycle = row_cnt==ROWS-1 && div_cnt==SCAN_DIV-1.
- Outputs are registered, updated every clk from current counters:
  - dot_row = one-hot of row_cnt at bit ROWS-1-row_cnt, inverted if ROW_ACTIVE_LOW.
  - dot_col = front[row_cnt].
  - Latency 1 cycle; first cycle after reset release shows row 0.
- frame_start=1 on the cycle the registered outputs first show row 0 of a frame, including the first after reset.
- Writes:
  - wr_ready = !commit_pending.
  - On accept, back[wr_row] <= wr_data.
  - wr_row >= ROWS (non-power-of-2 ROWS) is accepted and discarded.
  - Writes never touch the front bank.
- Commit:
  - commit sets commit_pending.
  - At a boundary cycle with (commit_pending || commit), bank_sel toggles and commit_pending clears at that edge.
  - The next displayed row (row 0) comes from the new front.
  - A write accepted in the same cycle as a commit, or in the swapping boundary cycle, lands in the committed frame.
  - commit while already pending has no extra effect.
  - After a swap the back bank holds the previously shown frame; no copy is made.
- Reset mid-frame or mid-commit: everything returns to reset values and the pending swap is lost.

Optional Feature:
- Macro MATRIX_GHOST_BLANK_EN.
- Defined: on the first cycle of each row dwell (div_cnt==0), the registered dot_col is forced to 0 and dot_row to all-inactive, to suppress ghosting. Row timing is unchanged. frame_start still pulses on the first row-0 cycle. Has no effect when SCAN_DIV==1.
- Undefined: no blanking.

Decomposition:
- Package matrix_pkg: row index width helper (clog2), ROW_INACTIVE constant function of ROW_ACTIVE_LOW, default ROWS/COLS.
- Sub-module matrix_frame_bank: ROWS x COLS register file with one sync write port, one async read port, async clear. Instantiated twice and selected by bank_sel.
- Scan counters, commit logic and output registers live in the top module.

Test Plan:
- ROWS=8, COLS=8, SCAN_DIV=1, release reset, no writes -> dot_row sequence 0x7F,0xBF,...,0xFE repeating every 8 cycles; dot_col=0; frame_start every 8th cycle starting at the first.
- Write rows 0..7 = 0x10,0,0x18,... then commit mid-frame -> commit_pending high until boundary, wr_ready low meanwhile; the next frame shows the new data from row 0, with no mixed frame.
- Commit and write (row 7 = 0xFF) in the same boundary cycle -> swap occurs; the following row 7 shows 0xFF.
- SCAN_DIV=3 -> each dot_row value held exactly 3 cycles; with MATRIX_GHOST_BLANK_EN, dot_col=0 and dot_row=0xFF on the first of each 3.
- ROWS=5, ROW_ACTIVE_LOW=0, write wr_row=6 -> write accepted and ignored; dot_row cycles 0x10,0x08,...,0x01.
- Assert rst mid-commit -> outputs immediately at reset values, commit_pending=0, banks zero.
